// File: rtl/maxset_loader.sv
// Streaming front end for the max-set engine: collects N words into a set, launches
// the engine, and returns its max result over a valid/ready handshake.
module maxset_loader #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [W-1:0]   in_data,
    output logic           in_ready,
    output logic [N*W-1:0] x_flat,
    output logic           start,
    input  logic           eng_done,
    input  logic [W-1:0]   eng_max,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    input  logic           out_ready,
    output logic           busy,
    output logic [15:0]    set_count
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             last_word;
    logic             capture;
    logic             handshake;
    logic             in_ready_d;
    logic             start_d;
    logic             busy_d;
    logic             out_valid_d;

    // in_ready is a flop that mirrors state==LOAD, so accept has no in_valid->in_ready path
    assign accept    = in_valid & in_ready;
    assign last_word = (idx == IDX_W'(N - 1));
    assign capture   = (state == S_WAIT) & eng_done;
    assign handshake = (state == S_OUT) & out_ready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_LOAD:  if (accept && last_word) next_state = S_START;
            S_START: next_state = S_WAIT;
            S_WAIT:  if (eng_done) next_state = S_OUT;
            S_OUT:   if (out_ready) next_state = S_LOAD;
            default: next_state = S_LOAD;
        endcase
    end

    // Output decode from the next state; the flops below make every control output registered
    always_comb begin
        in_ready_d  = 1'b0;
        start_d     = 1'b0;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        case (next_state)
            S_LOAD:  in_ready_d = 1'b1;
            S_START: begin
                start_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_WAIT:  busy_d = 1'b1;
            S_OUT:   out_valid_d = 1'b1;
            default: in_ready_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_ready  <= 1'b1;
            start     <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            start     <= start_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
        end
    end

    // Set assembly: entries are overwritten one by one, so the old set stays visible until replaced
    always_ff @(posedge clock) begin
        if (reset) begin
            idx    <= '0;
            x_flat <= '0;
        end else if (accept) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (idx == IDX_W'(i)) begin
                    x_flat[i*W +: W] <= in_data;
                end
            end
            idx <= last_word ? '0 : idx + IDX_W'(1);
        end
    end

    // Result capture and completed-set counter
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data  <= '0;
            set_count <= '0;
        end else begin
            if (capture) begin
                out_data <= eng_max;
            end
            if (handshake) begin
                set_count <= set_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_maxset_loader.sv
// Directed self-checking bench for maxset_loader (N=4, W=32).
module tb_maxset_loader;

    localparam int unsigned N = 4;
    localparam int unsigned W = 32;

    logic           clock;
    logic           reset;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic [N*W-1:0] x_flat;
    logic           start;
    logic           eng_done;
    logic [W-1:0]   eng_max;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic           busy;
    logic [15:0]    set_count;

    int vectors;
    int miscompares;

    maxset_loader #(.N(N), .W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .x_flat    (x_flat),
        .start     (start),
        .eng_done  (eng_done),
        .eng_max   (eng_max),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .set_count (set_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        check("in_ready_load", 128'(in_ready), 128'd1);
        step();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  128'(in_ready),  128'd1);
        check({tag, "_start"},     128'(start),     128'd0);
        check({tag, "_busy"},      128'(busy),      128'd0);
        check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        check({tag, "_out_data"},  128'(out_data),  128'd0);
        check({tag, "_x_flat"},    x_flat,          128'd0);
        check({tag, "_set_count"}, 128'(set_count), 128'd0);
    endtask

    initial begin
        int unsigned gap_v [7];
        logic [W-1:0] gap_w [4];
        int k;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        eng_done    = 1'b0;
        eng_max     = '0;
        out_ready   = 1'b1;

        step();
        step();
        check_reset_values("rst");
        reset = 1'b0;

        // Set 1: back-to-back words; eng_done asserted during LOAD and START must be ignored
        eng_done = 1'b1;
        eng_max  = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            check("s1_no_early_start", 128'(start), 128'd0);
            case (i)
                0: load_word(32'h5);
                1: load_word(32'h9);
                2: load_word(32'h3);
                default: load_word(32'h7);
            endcase
        end
        in_valid = 1'b0;
        check("s1_start",     128'(start),     128'd1);
        check("s1_busy",      128'(busy),      128'd1);
        check("s1_in_ready",  128'(in_ready),  128'd0);
        check("s1_x_flat",    x_flat, 128'h00000007_00000003_00000009_00000005);
        check("s1_no_cap_ld", 128'(out_data),  128'd0);
        step();
        check("s1_start_once",  128'(start),     128'd0);
        check("s1_busy_wait",   128'(busy),      128'd1);
        check("s1_no_cap_st_v", 128'(out_valid), 128'd0);
        check("s1_no_cap_st_d", 128'(out_data),  128'd0);
        eng_done = 1'b0;
        step();
        eng_done = 1'b1;
        eng_max  = 32'h9;
        step();
        eng_done = 1'b0;
        check("s1_out_valid", 128'(out_valid), 128'd1);
        check("s1_out_data",  128'(out_data),  128'h9);
        check("s1_busy_out",  128'(busy),      128'd0);
        check("s1_x_hold",    x_flat, 128'h00000007_00000003_00000009_00000005);
        step();
        check("s1_out_1cyc",  128'(out_valid), 128'd0);
        check("s1_set_count", 128'(set_count), 128'd1);
        check("s1_in_ready",  128'(in_ready),  128'd1);

        // Set 2: downstream stalls for 5 cycles while a sender offers extra words
        out_ready = 1'b0;
        load_word(32'h11);
        check("s2_partial", x_flat, 128'h00000007_00000003_00000009_00000011);
        load_word(32'h22);
        load_word(32'h33);
        load_word(32'h44);
        in_valid = 1'b0;
        check("s2_start", 128'(start), 128'd1);
        step();
        eng_done = 1'b1;
        eng_max  = 32'h44;
        step();
        eng_done = 1'b0;
        eng_max  = 32'h0;
        in_valid = 1'b1;
        in_data  = 32'h0BAD;
        for (int i = 0; i < 5; i++) begin
            check("s2_hold_valid", 128'(out_valid), 128'd1);
            check("s2_hold_data",  128'(out_data),  128'h44);
            check("s2_hold_rdy",   128'(in_ready),  128'd0);
            step();
        end
        check("s2_x_no_consume", x_flat, 128'h00000044_00000033_00000022_00000011);
        check("s2_count_stall",  128'(set_count), 128'd1);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("s2_set_count", 128'(set_count), 128'd2);
        check("s2_out_valid", 128'(out_valid), 128'd0);
        check("s2_in_ready",  128'(in_ready),  128'd1);
        step();
        check("s2_x_after",   x_flat, 128'h00000044_00000033_00000022_00000011);
        check("s2_count_one", 128'(set_count), 128'd2);

        // Set 3: gapped input valid pattern 1,0,0,1,1,0,1
        gap_v = '{1, 0, 0, 1, 1, 0, 1};
        gap_w = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        k = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = (gap_v[i] != 0);
            in_data  = (gap_v[i] != 0) ? gap_w[k] : 32'hFFFF_FFFF;
            check("s3_no_start", 128'(start), 128'd0);
            step();
            if (gap_v[i] != 0) k++;
        end
        in_valid = 1'b0;
        check("s3_start",  128'(start), 128'd1);
        check("s3_x_flat", x_flat, 128'h000000A4_000000A3_000000A2_000000A1);
        step();
        eng_done = 1'b1;
        eng_max  = 32'hA4;
        step();
        eng_done = 1'b0;
        check("s3_out_data", 128'(out_data), 128'hA4);
        step();
        check("s3_set_count", 128'(set_count), 128'd3);

        // Reset mid-load discards the partial set
        load_word(32'hB1);
        load_word(32'hB2);
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        check_reset_values("rst_load");
        reset = 1'b0;
        load_word(32'hC1);
        load_word(32'hC2);
        load_word(32'hC3);
        load_word(32'hC4);
        in_valid = 1'b0;
        check("s4_x_fresh", x_flat, 128'h000000C4_000000C3_000000C2_000000C1);
        check("s4_start",   128'(start), 128'd1);
        step();

        // Reset during WAIT wins over a simultaneous eng_done
        reset    = 1'b1;
        eng_done = 1'b1;
        eng_max  = 32'h55;
        step();
        check_reset_values("rst_wait");
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("s5_idle_start", 128'(start),     128'd0);
            check("s5_idle_valid", 128'(out_valid), 128'd0);
            check("s5_idle_busy",  128'(busy),      128'd0);
        end
        eng_done = 1'b0;
        load_word(32'hD1);
        load_word(32'hD2);
        load_word(32'hD3);
        load_word(32'hD4);
        in_valid = 1'b0;
        check("s5_x_fresh", x_flat, 128'h000000D4_000000D3_000000D2_000000D1);
        check("s5_start",   128'(start), 128'd1);
        step();
        eng_done = 1'b1;
        eng_max  = 32'hD4;
        step();
        eng_done = 1'b0;
        check("s5_out_valid", 128'(out_valid), 128'd1);
        check("s5_out_data",  128'(out_data),  128'hD4);
        step();
        check("s5_set_count", 128'(set_count), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
